// File: rtl/ws2812b_defs_pkg.sv
// ws2812b_defs_pkg
//   Constants shared by the WS2812B transmit and receive paths: FSM state
//   encodings, error codes and default pulse timings derived from the clock.
package ws2812b_defs_pkg;

    // Receiver FSM states (debug_info[3:2] exposes these directly)
    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    // Error codes reported on error_code
    localparam logic [1:0] ERR_GLITCH  = 2'd0;
    localparam logic [1:0] ERR_STUCK   = 2'd1;
    localparam logic [1:0] ERR_PARTIAL = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef struct packed {
        logic       vld;
        logic [1:0] code;
    } err_evt_t;

    function automatic int ns_to_cycles(input longint fclk_hz, input longint ns);
        return int'((fclk_hz * ns) / 64'd1_000_000_000);
    endfunction

    localparam longint FCLK_HZ   = 21_000_000;
    localparam int     CYC_SHORT = ns_to_cycles(FCLK_HZ, 400);    // 8
    localparam int     CYC_LONG  = ns_to_cycles(FCLK_HZ, 800);    // 16
    localparam int     CYC_RET   = ns_to_cycles(FCLK_HZ, 50_000); // 1050

    // Decision point halfway between a short and a long high time
    localparam int DEF_THRESHOLD = (CYC_SHORT + CYC_LONG) / 2;    // 12
    localparam int DEF_MIN_HIGH  = 3;
    localparam int DEF_MAX_HIGH  = 40;

endpackage

// File: rtl/ws2812b_in_module_sync_edge_detect.sv
// sync_edge_detect
//   Two-flop synchronizer for an asynchronous input followed by a one-cycle
//   history register that yields single-cycle rise/fall strobes.
//   Ports: clk, resetn (async low), d (async input),
//          q (synchronized level), rise, fall (1-cycle strobes aligned to q).
module sync_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta, s, s_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta   <= 1'b0;
            s      <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            meta   <= d;
            s      <= meta;
            s_prev <= s;
        end
    end

    assign q    = s;
    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

endmodule

// File: rtl/ws2812b_in_module.sv
// ws2812b_in_module
//   WS2812B line decoder. Classifies each high pulse by length, assembles
//   24-bit {G,R,B} words MSB first, and ends a frame on the long low gap.
//   Ports: clk, resetn (async low), ws2812b_in (raw line),
//          bitstream/bitstream_available/bitstream_read (word handshake),
//          frame_done + led_count (frame end, word count),
//          error + error_code (1-cycle pulse, code held),
//          debug_info {state, s_in, bitstream_available}.
module ws2812b_in_module
    import ws2812b_defs_pkg::*;
#(
    parameter int CYCLES_THRESHOLD = DEF_THRESHOLD,
    parameter int CYCLES_MIN_HIGH  = DEF_MIN_HIGH,
    parameter int CYCLES_MAX_HIGH  = DEF_MAX_HIGH,
    parameter int CYCLES_RET       = CYC_RET,
    parameter int LED_COUNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ws2812b_in,
    output logic [23:0]            bitstream,
    output logic                   bitstream_available,
    input  logic                   bitstream_read,
    output logic                   frame_done,
    output logic [LED_COUNT_W-1:0] led_count,
    output logic                   error,
    output logic [1:0]             error_code,
    output logic [3:0]             debug_info
);

    localparam int CNT_MAX = (CYCLES_RET > CYCLES_MAX_HIGH) ? CYCLES_RET : CYCLES_MAX_HIGH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_THR   = CNT_W'(CYCLES_THRESHOLD);
    localparam logic [CNT_W-1:0] C_MIN   = CNT_W'(CYCLES_MIN_HIGH);
    localparam logic [CNT_W-1:0] C_MAX   = CNT_W'(CYCLES_MAX_HIGH);
    localparam logic [CNT_W-1:0] C_RET   = CNT_W'(CYCLES_RET);
    localparam logic [CNT_W-1:0] C_RET_1 = CNT_W'(CYCLES_RET - 1);

    logic                   s_in, rise, fall;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt, cnt_inc;
    logic [4:0]             bit_cnt;
    logic [LED_COUNT_W-1:0] word_cnt;
    logic [23:0]            shreg;
    logic                   word_done;
    logic                   glitch, stuck, gap_end, partial, overrun;
    err_evt_t               err_evt;

    sync_edge_detect u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (ws2812b_in),
        .q      (s_in),
        .rise   (rise),
        .fall   (fall)
    );

    // cnt holds the number of cycles spent at the current level, so a pulse
    // of N synchronized high cycles shows cnt==N on its fall strobe.
    assign cnt_inc = (cnt == C_RET) ? cnt : cnt + 1'b1;

    assign glitch  = (state == ST_HIGH) && fall && (cnt < C_MIN);
    assign stuck   = (state == ST_HIGH) && !fall && (cnt_inc == C_MAX);
    assign gap_end = (state == ST_LOW) && !rise && (cnt_inc == C_RET);
    assign partial = gap_end && (bit_cnt != 5'd0);
    // word_done loads the output this cycle; an unread word gets clobbered
    assign overrun = word_done && bitstream_available && !bitstream_read;

    always_comb begin
        err_evt = '0;
        if (glitch)       err_evt = '{vld: 1'b1, code: ERR_GLITCH};
        else if (stuck)   err_evt = '{vld: 1'b1, code: ERR_STUCK};
        else if (partial) err_evt = '{vld: 1'b1, code: ERR_PARTIAL};
        else if (overrun) err_evt = '{vld: 1'b1, code: ERR_OVERRUN};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_SYNC;
            cnt        <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shreg      <= '0;
            word_done  <= 1'b0;
            frame_done <= 1'b0;
            led_count  <= '0;
        end else begin
            word_done  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_SYNC: begin
                    if (s_in) begin
                        cnt <= '0;
                    end else if (cnt == C_RET_1) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_IDLE: begin
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (glitch || stuck) begin
                        // Frame is corrupt: drop partial word and frame count,
                        // then wait for a clean gap before decoding again.
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                        state    <= ST_SYNC;
                    end else if (fall) begin
                        shreg <= {shreg[22:0], (cnt >= C_THR)};
                        if (bit_cnt == 5'd23) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                            if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        cnt   <= CNT_ONE;
                        state <= ST_LOW;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= ST_HIGH;
                    end else if (gap_end) begin
                        frame_done <= 1'b1;
                        led_count  <= word_cnt;
                        word_cnt   <= '0;
                        bit_cnt    <= '0;
                        cnt        <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bitstream           <= '0;
            bitstream_available <= 1'b0;
            error               <= 1'b0;
            error_code          <= '0;
        end else begin
            if (word_done) begin
                bitstream           <= shreg;
                bitstream_available <= 1'b1;
            end else if (bitstream_read) begin
                bitstream_available <= 1'b0;
            end
            error <= err_evt.vld;
            if (err_evt.vld) error_code <= err_evt.code;
        end
    end

    assign debug_info = {state, s_in, bitstream_available};

endmodule
